// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS CPU memory-bus arbiter: FSM states, master index
// and the latched slave command.
package mips_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = BUS_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RESP
    } bus_state_e;

    typedef logic master_idx_t;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] address;
        logic [BUS_DATA_W-1:0] writedata;
        logic [BUS_BE_W-1:0]   byteenable;
        logic                  is_read;
    } bus_cmd_t;

    function automatic master_idx_t other_master(input master_idx_t g);
        return ~g;
    endfunction

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Two-way round-robin pick: on a tie the master that did not win last time
// gets the bus, otherwise the single requester wins.
module mips_bus_rr_pick
    import mips_bus_pkg::*;
(
    input  logic [1:0]  req,
    input  master_idx_t last_grant,
    output logic        valid,
    output master_idx_t winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (&req) begin
            winner = other_master(last_grant);
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates the data-access (0) and instruction-fetch (1) ports of the MIPS
// CPU onto one Avalon-style slave bus with a registered command.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no transfer; pick a requester and latch its command
// ST_CMD  | command on the slave bus, waiting for s_waitrequest low
// ST_RESP | read data returned to the granted master this cycle
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m_address     [2],
    input  logic                m_read        [2],
    input  logic                m_write       [2],
    input  logic [DATA_W-1:0]   m_writedata   [2],
    input  logic [DATA_W/8-1:0] m_byteenable  [2],
    output logic                m_waitrequest [2],
    output logic [DATA_W-1:0]   m_readdata    [2],
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata
);

    bus_state_e  state_q, state_d;
    bus_cmd_t    cmd_q, cmd_d, load_cmd;
    master_idx_t grant_q, grant_d;
    master_idx_t last_grant_q, last_grant_d;
    master_idx_t load_idx, pick_winner, other_idx;
    logic [1:0]  req;
    logic        pick_valid;
    logic        load;
    logic        done;

    assign req       = {m_read[1] | m_write[1], m_read[0] | m_write[0]};
    assign other_idx = other_master(grant_q);

    mips_bus_rr_pick u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // A read-and-write request is treated as a read.
    assign load_cmd = '{
        address:    m_address[load_idx],
        writedata:  m_writedata[load_idx],
        byteenable: m_byteenable[load_idx],
        is_read:    m_read[load_idx]
    };

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        load         = 1'b0;
        load_idx     = pick_winner;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    load     = 1'b1;
                    grant_d  = pick_winner;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!s_waitrequest) begin
                    if (cmd_q.is_read) state_d = ST_RESP;
                    else               done    = 1'b1;
                end
            end
            ST_RESP: done = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        // The finishing master's request is stale this edge; only the other
        // master may be handed the bus without an idle cycle.
        if (done) begin
            last_grant_d = grant_q;
            if (req[other_idx]) begin
                load     = 1'b1;
                load_idx = other_idx;
                grant_d  = other_idx;
                state_d  = ST_CMD;
            end else begin
                state_d  = ST_IDLE;
            end
        end

        cmd_d = load ? load_cmd : cmd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign s_address    = cmd_q.address;
    assign s_writedata  = cmd_q.writedata;
    assign s_byteenable = cmd_q.byteenable;
    assign s_read       = (state_q == ST_CMD) &&  cmd_q.is_read;
    assign s_write      = (state_q == ST_CMD) && !cmd_q.is_read;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_waitrequest[i] = !(done && (grant_q == i[0]));
            m_readdata[i]    = ((state_q == ST_RESP) && (grant_q == i[0])) ? s_readdata : '0;
        end
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter sharing the single Avalon-style memory bus between the MIPS CPU's data-access port (master 0) and instruction-fetch port (master 1). It grants one master at a time, registers the granted command onto the slave bus, honours slave `waitrequest`, and returns read data with a fixed one-cycle slave read latency. It sits between `mips_cpu_bus` internals and the external memory/bus interface.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byteenable width is `DATA_W/8`.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
- `m_address[i]`  in  ADDR_W  master i address, i in {0,1}.
- `m_read[i]`, `m_write[i]`  in  1  master i request strobes; held until completion.
- `m_writedata[i]`  in  DATA_W  master i write data.
- `m_byteenable[i]`  in  DATA_W/8  master i byte lanes.
- `m_waitrequest[i]`  out  1  low only in master i's completion cycle.
- `m_readdata[i]`  out  DATA_W  valid when `m_waitrequest[i]`=0 after a read.
- `s_address`  out  ADDR_W; `s_read`, `s_write`  out  1; `s_writedata`  out  DATA_W; `s_byteenable`  out  DATA_W/8: registered slave command.
- `s_waitrequest`  in  1  slave stall.
- `s_readdata`  in  DATA_W  slave data, valid the cycle after read acceptance.

## Operation
- States: IDLE, CMD, RESP.
- IDLE: if any `m_read|m_write` set, pick winner, latch its address/data/byteenable/op into command register, go CMD.
- Pick: both requesting -> master that did not win last (`last_grant`); one requesting -> that one. `last_grant` resets to 1, so master 0 wins the first contest.
- CMD: drive `s_read`/`s_write` from command register. Acceptance = edge with `s_waitrequest`=0.
  - Write accepted: `m_waitrequest[g]`=0 in that same cycle (combinational from `s_waitrequest`); transfer done at that edge.
  - Read accepted: go RESP.
- RESP: `m_readdata[g]`=`s_readdata`, `m_waitrequest[g]`=0; transfer done at end of cycle. `s_read`/`s_write` low.
- On done: `last_grant`<=g. If the other master requests, grant it directly (next state CMD); else IDLE. Completed master's own request is stale that edge and never re-granted directly.
- `m_read` and `m_write` both set: treated as read.
- `m_readdata[i]` = 0 when not in RESP for i.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, `s_read`=`s_write`=0, `s_address`/`s_writedata`=0, `s_byteenable`=0, `m_waitrequest`=1 both, `m_readdata`=0, `last_grant`=1. In-flight transfer abandoned; slave strobes drop without waiting for a clock.
- Read, no slave stall: request cycle 0 (IDLE), `s_read` cycle 1, RESP cycle 2 (`m_waitrequest`=0); master samples data at end of cycle 2 -> 3 cycles.
- Write, no stall: `s_write` cycle 1 with `m_waitrequest`=0 -> 2 cycles.
- Each slave stall cycle adds one cycle in CMD; command register held stable throughout.
- Back-to-back alternating masters: no IDLE bubble; same master repeating: one IDLE cycle between transfers.
- `m_waitrequest[i]` is 1 in every other cycle, including while idle.

## Structure
- Package `mips_bus_pkg`: state enum (IDLE/CMD/RESP), master index type, command struct (address, writedata, byteenable, is_read).
- One sub-module: `mips_bus_rr_pick` — combinational 2-way round-robin pick from request vector and `last_grant`, outputs valid and winner index.

## Test plan
- Reset, then master 0 reads 0x4 with slave returning 0x5C3AF8FC, no stall -> `s_read` cycle 1, `m_readdata[0]`=0x5C3AF8FC with `m_waitrequest[0]`=0 in cycle 2 only.
- Both masters request same cycle after reset (m0 write 0x8, m1 read 0xBFC00000) -> m0 granted first, m1 `s_read` directly in cycle after m0 write completes, no IDLE gap; next contest goes to m0.
- Slave holds `s_waitrequest`=1 for 3 cycles on m1 write of 0x2EAC06 with byteenable 0011 -> `s_address`/`s_writedata`/`s_byteenable` stable 4 cycles, `m_waitrequest[1]` low only in the 4th.
- Master 1 issues two consecutive reads alone -> exactly one IDLE cycle between RESP and next `s_read`.
- Assert `reset`=0 mid-CMD between clock edges -> `s_read`, `s_write` drop immediately; after release m0 wins a simultaneous contest.
- Master 0 drives `m_read`=`m_write`=1 -> `s_read`=1, `s_write`=0.
